cc_cond_unit: RTL

- Execute-stage consumer of the 64-bit adder/subtractor outputs (result word and signed-overflow flag).
- Owns the architectural condition-code register {ZF, SF, OF}.
- Evaluates jXX/cmovXX conditions against the stored flags.
- Cancels the cmov destination register when the move condition is false.
- Sits between the ALU and the E→M pipeline register of the pipelined Y86-64 core.

---
 rtl/cc_cond_unit_pkg.sv | 40 ++++
 rtl/cc_cond_unit_if.sv | 24 ++
 rtl/cc_cond_unit_cond_eval.sv | 28 ++
 rtl/cc_cond_unit.sv | 57 +++++
 4 files changed

// File: rtl/cc_cond_unit_pkg.sv
// Shared Y86-64 encodings used by the Execute-stage condition-code logic.
package y86_pkg;

  localparam int unsigned WORD_W = 64;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/cc_cond_unit_if.sv
// Execute-stage bundle between the ALU/pipeline control and the condition-code unit.
interface cc_cond_unit_if #(parameter int unsigned WORD_W = 64);
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [3:0]        E_dstE;
  logic [WORD_W-1:0] alu_sum;
  logic              alu_of;
  logic [3:0]        m_stat;
  logic [3:0]        W_stat;
  logic [2:0]        cc;
  logic              set_cc;
  logic              e_cnd;
  logic [3:0]        e_dstE;

  modport master (
    output E_icode, E_ifun, E_dstE, alu_sum, alu_of, m_stat, W_stat,
    input  cc, set_cc, e_cnd, e_dstE
  );

  modport slave (
    input  E_icode, E_ifun, E_dstE, alu_sum, alu_of, m_stat, W_stat,
    output cc, set_cc, e_cnd, e_dstE
  );
endinterface

// File: rtl/cc_cond_unit_cond_eval.sv
// Pure combinational jXX/cmovXX condition decode from the stored flags.
import y86_pkg::*;

module cond_eval (
  input  logic [3:0] ifun_i,
  input  cc_t        cc_i,
  output logic       cnd_o
);

  logic lt_s;

  assign lt_s = cc_i.sf ^ cc_i.of;

  always_comb begin
    cnd_o = 1'b0;
    case (ifun_i)
      C_ALWAYS: cnd_o = 1'b1;
      C_LE:     cnd_o = lt_s | cc_i.zf;
      C_L:      cnd_o = lt_s;
      C_E:      cnd_o = cc_i.zf;
      C_NE:     cnd_o = ~cc_i.zf;
      C_GE:     cnd_o = ~lt_s;
      C_G:      cnd_o = ~lt_s & ~cc_i.zf;
      default:  cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Architectural {ZF,SF,OF} register, its write gating, and cmov destination cancel.
import y86_pkg::*;

module cc_cond_unit #(
  parameter int unsigned WORD_W   = 64,
  parameter cc_t         CC_RESET = 3'b100
) (
  input logic            clk,
  input logic            reset,
  cc_cond_unit_if.slave  bus
);

  cc_t  cc_q;
  cc_t  cc_d;
  logic set_cc_s;
  logic cnd_raw_s;
  logic e_cnd_s;

  // Flags freeze while an older instruction in M or W is exceptional.
  assign set_cc_s = (bus.E_icode == I_OPQ) && (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);

  always_comb begin
    cc_d = cc_q;
    if (set_cc_s) begin
      case (bus.E_ifun)
        A_ADD, A_SUB: cc_d = '{zf: (bus.alu_sum == '0), sf: bus.alu_sum[WORD_W-1], of: bus.alu_of};
        A_AND, A_XOR: cc_d = '{zf: (bus.alu_sum == '0), sf: bus.alu_sum[WORD_W-1], of: 1'b0};
        default:      cc_d = cc_q;
      endcase
    end else begin
      cc_d = cc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  cond_eval u_cond_eval (
    .ifun_i (bus.E_ifun),
    .cc_i   (cc_q),
    .cnd_o  (cnd_raw_s)
  );

  // Conditions are evaluated from the registered flags, never the in-flight ALU result.
  assign e_cnd_s = ((bus.E_icode == I_JXX) || (bus.E_icode == I_CMOVXX)) ? cnd_raw_s : 1'b0;

  assign bus.cc     = cc_q;
  assign bus.set_cc = set_cc_s;
  assign bus.e_cnd  = e_cnd_s;
  assign bus.e_dstE = ((bus.E_icode == I_CMOVXX) && !e_cnd_s) ? RNONE : bus.E_dstE;

endmodule
